// File: rtl/riscv_mdu.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with divide-by-zero and signed-overflow shortcuts.
module riscv_mdu #(
  parameter int BITNESS = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [2:0]         funct3_i,
  input  logic [BITNESS-1:0] op_a_i,
  input  logic [BITNESS-1:0] op_b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BITNESS-1:0] result_o
);
  localparam int W  = BITNESS;
  localparam int CW = $clog2(BITNESS) + 1;
  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  LAST_CNT = CW'(W - 1);
  localparam logic [CW-1:0]  ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return (~v) + ONE_W;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return (~v) + ONE_2W;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      funct3_r;
  logic            neg_r;
  logic [W-1:0]    mag_x_r;
  logic [2*W-1:0]  acc_r, acc_nxt_s;
  logic [W-1:0]    result_r;
  logic            busy_r, done_r, busy_nxt_s, done_nxt_s;

  logic            accept_s, last_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic            div_zero_s, div_ovf_s, special_s, sign_s;
  logic [W-1:0]    mag_a_s, mag_b_s, special_res_s, final_res_s;
  logic [W:0]      mul_sum_s, div_diff_s;
  logic [2*W-1:0]  prod_fix_s;

  assign accept_s   = start_i && (state_r != CALC);
  assign last_s     = (state_r == CALC) && (cnt_r == LAST_CNT);
  assign a_signed_s = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign b_signed_s = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign a_neg_s    = a_signed_s && op_a_i[W-1];
  assign b_neg_s    = b_signed_s && op_b_i[W-1];
  assign mag_a_s    = a_neg_s ? neg_w(op_a_i) : op_a_i;
  assign mag_b_s    = b_neg_s ? neg_w(op_b_i) : op_b_i;
  assign div_zero_s = funct3_i[2] && (op_b_i == {W{1'b0}});
  assign div_ovf_s  = funct3_i[2] && !funct3_i[0] && (op_a_i == {1'b1, {(W-1){1'b0}}}) &&
                      (op_b_i == {W{1'b1}});
  assign special_s  = div_zero_s || div_ovf_s;
  assign mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, mag_x_r} : {(W+1){1'b0}});
  assign div_diff_s = {acc_r[2*W-1:W], acc_r[W-1]} - {1'b0, mag_x_r};
  assign prod_fix_s = neg_r ? neg_2w(acc_nxt_s) : acc_nxt_s;

  // Sign of the final result, decided from the raw operands when accepted
  always_comb begin
    sign_s = 1'b0;
    case (funct3_i)
      3'b001, 3'b100: sign_s = a_neg_s ^ b_neg_s;
      3'b010, 3'b110: sign_s = a_neg_s;
      default:        sign_s = 1'b0;
    endcase
  end

  // Shortcut results for divide-by-zero and most-negative / -1
  always_comb begin
    special_res_s = {W{1'b0}};
    if (div_zero_s) begin
      special_res_s = funct3_i[1] ? op_a_i : {W{1'b1}};
    end else begin
      special_res_s = funct3_i[1] ? {W{1'b0}} : op_a_i;
    end
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    acc_nxt_s = acc_r;
    if (!funct3_r[2]) begin
      acc_nxt_s = {mul_sum_s, acc_r[W-1:1]};
    end else if (!div_diff_s[W]) begin
      acc_nxt_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
    end else begin
      acc_nxt_s = {acc_r[2*W-2:0], 1'b0};
    end
  end

  // Sign fix-up and result select applied on the final iteration
  always_comb begin
    final_res_s = {W{1'b0}};
    case (funct3_r)
      3'b000:                 final_res_s = acc_nxt_s[W-1:0];
      3'b001, 3'b010, 3'b011: final_res_s = prod_fix_s[2*W-1:W];
      3'b100, 3'b101:         final_res_s = neg_r ? neg_w(acc_nxt_s[W-1:0]) : acc_nxt_s[W-1:0];
      3'b110, 3'b111:         final_res_s = neg_r ? neg_w(acc_nxt_s[2*W-1:W]) : acc_nxt_s[2*W-1:W];
      default:                final_res_s = {W{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_nxt_s = special_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_nxt_s = (state_nxt_s == CALC);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r    <= {CW{1'b0}};
      funct3_r <= 3'b000;
      neg_r    <= 1'b0;
      mag_x_r  <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      result_r <= {W{1'b0}};
    end else if (accept_s) begin
      cnt_r    <= {CW{1'b0}};
      funct3_r <= funct3_i;
      neg_r    <= sign_s;
      if (funct3_i[2]) begin
        mag_x_r <= mag_b_s;
        acc_r   <= {{W{1'b0}}, mag_a_s};
      end else begin
        mag_x_r <= mag_a_s;
        acc_r   <= {{W{1'b0}}, mag_b_s};
      end
      if (special_s) begin
        result_r <= special_res_s;
      end
    end else if (state_r == CALC) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r + ONE_CNT;
      if (last_s) begin
        result_r <= final_res_s;
      end
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;
endmodule

// File: tb/tb_riscv_mdu.sv
// Scoreboard bench for riscv_mdu (BITNESS=32): expected results are queued at
// launch and compared when done_o pulses; latency and busy cycles are checked too.
module tb_riscv_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  riscv_mdu #(.BITNESS(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard: every done_o cycle consumes one expected result
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, result, e.value);
      end
    end
  end

  task automatic launch(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v);
    exp_t e;
    e.tag = tag;
    e.value = exp_v;
    funct3 = f3;
    op_a = a;
    op_b = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done_o; optionally drops start at cycle release_at
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int release_at);
    int k = 0;
    int nb = 0;
    int seen = 0;
    while (k < 200 && seen == 0) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (done) seen = 1;
      if (k == release_at) start = 1'b0;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    int saved_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    launch("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    wait_done("mul", 33, 32, 0);
    launch("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    wait_done("mulhu_b2b", 33, 32, 0);
    launch("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    wait_done("mulh", 33, 32, 0);
    launch("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    wait_done("mulhsu", 33, 32, 0);
    launch("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    wait_done("div", 33, 32, 0);
    launch("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    wait_done("rem", 33, 32, 0);
    launch("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    wait_done("divu", 33, 32, 0);
    launch("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    wait_done("remu", 33, 32, 0);
    launch("mul_signed", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA);
    wait_done("mul_signed", 33, 32, 0);
    launch("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
    wait_done("divu_zero", 1, 0, 0);
    launch("remu_zero", 3'b111, 32'd5, 32'd0, 32'd5);
    wait_done("remu_zero", 1, 0, 0);
    launch("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    wait_done("div_ovf", 1, 0, 0);
    launch("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    wait_done("rem_ovf", 1, 0, 0);
    launch("divu_after_special", 3'b101, 32'd1000, 32'd10, 32'd100);
    wait_done("divu_after_special", 33, 32, 0);

    // start held through CALC must be ignored
    @(negedge clk);
    @(negedge clk);
    launch("held_mul", 3'b000, 32'd3, 32'd5, 32'd15);
    funct3 = 3'b101;
    op_a = 32'd100;
    op_b = 32'd7;
    start = 1'b1;
    wait_done("held", 33, 32, 20);
    @(negedge clk);
    check("held_hold_result", result, 32'd15);
    check("held_no_done", {31'd0, done}, 32'd0);

    // Reset ten cycles into a multiply aborts it silently
    repeat (2) @(negedge clk);
    funct3 = 3'b000;
    op_a = 32'd9;
    op_b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    saved_done = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(saved_done));

    launch("first_after_rst", 3'b000, 32'd12, 32'd11, 32'd132);
    wait_done("first_after_rst", 33, 32, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
